// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
package mul_pkg;

    localparam int N_BITS = 32;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10,
        S_BAD  = 2'b11
    } state_e;

endpackage

// File: rtl/mul_seq_ctrl_cla.sv
// 32-bit two-level carry-lookahead adder: eight 4-bit lookahead groups
// whose group generate/propagate terms feed a second carry level.
module CLA32bit (
    output logic [31:0] s,
    output logic        cout,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [8:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int i = 0; i < 8; i++) begin
            gg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            gp[i] = &p[4*i +: 4];
        end
        gc[0] = cin;
        for (int i = 0; i < 8; i++) begin
            gc[i+1] = gg[i] | (gp[i] & gc[i]);
        end
        // In-group carries are expanded from the group carry-in.
        for (int i = 0; i < 8; i++) begin
            c[4*i]   = gc[i];
            c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
            c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i])
                     | (p[4*i+1] & p[4*i] & gc[i]);
            c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                     | (p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
        end
    end

    assign s    = p ^ c;
    assign cout = gc[8];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential 32x32 unsigned shift-add multiplier: one shared CLA adder,
// a 64-bit accumulator/shift register and a three-state controller.
module mul_seq_ctrl
    import mul_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_BITS-1:0]     a,
    input  logic [N_BITS-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*N_BITS-1:0]   product,
    output logic [1:0]            state_dbg
);

    state_e              state_q, state_d;
    logic [N_BITS-1:0]   mcand_q, mcand_d;
    logic [N_BITS-1:0]   acc_hi_q, acc_hi_d;
    logic [N_BITS-1:0]   acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [N_BITS-1:0]   add_b;
    logic [N_BITS-1:0]   sum;
    logic                cout;

    // Multiplier LSB selects whether this iteration adds the multiplicand.
    assign add_b = acc_lo_q[0] ? mcand_q : '0;

    CLA32bit u_cla (
        .s    (sum),
        .cout (cout),
        .a    (acc_hi_q),
        .b    (add_b),
        .cin  (1'b0)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    acc_hi_d = '0;
                    acc_lo_d = b;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // Carry-out lands in the top bit, so no product bit is lost.
                acc_hi_d = {cout, sum[N_BITS-1:1]};
                acc_lo_d = {sum[0], acc_lo_q[N_BITS-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N_BITS - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign done      = (state_q == S_DONE);
    assign product   = {acc_hi_q, acc_lo_q};
    assign state_dbg = state_q;

endmodule
